// File: rtl/freq_to_wavelength.sv
// rtl/freq_to_wavelength.sv - converts a Q12.20 tone frequency into an oscillator period in clk cycles
// using a 64-step restoring divider; the published period is registered and held between updates.
module freq_to_wavelength #(
  parameter int CLOCK_FREQUENCY = 24000000,
  parameter int FRAC_BITS       = 20,
  parameter int RESET_LENGTH    = 436363
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] freq,
  input  logic        freq_valid,
  output logic        freq_ready,
  output logic [31:0] wave_length,
  output logic        wave_length_valid,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    PUBLISH
  } state_t;

  localparam logic [63:0] DIVIDEND_INIT = 64'(CLOCK_FREQUENCY) << FRAC_BITS;
  localparam logic [31:0] RESET_WL      = 32'(RESET_LENGTH);

  state_t      state;
  state_t      next_state;
  logic [31:0] divisor;
  logic [63:0] dividend;
  logic [31:0] remainder;
  logic [5:0]  count;
  logic        accept;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        fits;

  assign accept    = (state == IDLE) && freq_ready && freq_valid;
  assign rem_shift = {remainder, dividend[63]};
  assign rem_diff  = rem_shift - {1'b0, divisor};
  // No borrow out of the trial subtraction means the shifted remainder covers the divisor.
  assign fits      = ~rem_diff[32];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (freq == 32'd0) ? PUBLISH : DIVIDE;
        end
      end
      DIVIDE: begin
        if (count == 6'd0) begin
          next_state = PUBLISH;
        end
      end
      PUBLISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient: each step shifts in one quotient bit at the LSB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wave_length       <= RESET_WL;
      wave_length_valid <= 1'b0;
      overflow          <= 1'b0;
      div_by_zero       <= 1'b0;
      freq_ready        <= 1'b0;
      divisor           <= 32'd0;
      dividend          <= 64'd0;
      remainder         <= 32'd0;
      count             <= 6'd0;
    end else begin
      freq_ready        <= (next_state == IDLE);
      wave_length_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            divisor     <= freq;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            dividend    <= DIVIDEND_INIT;
            remainder   <= 32'd0;
            count       <= 6'd63;
          end
        end
        DIVIDE: begin
          dividend  <= {dividend[62:0], fits};
          remainder <= fits ? rem_diff[31:0] : rem_shift[31:0];
          count     <= count - 6'd1;
        end
        PUBLISH: begin
          wave_length_valid <= 1'b1;
          if (divisor == 32'd0) begin
            wave_length <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else if (dividend[63:32] != 32'd0) begin
            wave_length <= 32'hFFFF_FFFF;
            overflow    <= 1'b1;
          end else begin
            wave_length <= dividend[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
